// File: rtl/cdc_reg_responder.sv
// Byte-command responder behind a CDC core: 'R' addr / 'W' addr data / 'V'.
// Eight 8-bit registers, single-byte replies, inter-byte abort timeout.
//
// state    | meaning
// IDLE     | waiting for a command byte (CR/LF ignored)
// GET_ADDR | 'R' or 'W' received, waiting for the address byte
// GET_DATA | 'W' and address received, waiting for the data byte
// RESP     | reply byte presented on in_data_o until accepted
module cdc_reg_responder #(
  parameter logic [7:0]  VERSION        = 8'h01,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd48000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [7:0]  out_data_i,
  input  logic        out_valid_i,
  output logic        out_ready_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  output logic [63:0] regs_o,
  output logic [7:0]  err_count_o
);

  typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA, RESP} state_e;

  localparam logic [7:0]  CH_CR  = 8'h0D;
  localparam logic [7:0]  CH_LF  = 8'h0A;
  localparam logic [7:0]  CH_R   = 8'h52;
  localparam logic [7:0]  CH_W   = 8'h57;
  localparam logic [7:0]  CH_V   = 8'h56;
  localparam logic [7:0]  CH_ERR = 8'h3F;
  localparam logic [7:0]  CH_OK  = 8'h4B;
  localparam logic [15:0] TMO_LAST = TIMEOUT_CYCLES - 16'd1;

  state_e      state_q, state_d;
  logic        op_wr_q, op_wr_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  reply_q, reply_d;
  logic [7:0]  err_q, err_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  regs_q [8];

  logic        rx_fire;
  logic        tx_fire;
  logic        tmo_hit;
  logic        err_inc;
  logic        wr_en;

  assign out_ready_o = (state_q != RESP);
  assign in_valid_o  = (state_q == RESP);
  assign in_data_o   = reply_q;
  assign err_count_o = err_q;
  assign rx_fire     = out_valid_i & out_ready_o;
  assign tx_fire     = in_valid_o & in_ready_i;

  // The abort fires only on a quiet cycle; an arriving byte always wins.
  assign tmo_hit = (TIMEOUT_CYCLES != 16'd0) && !rx_fire && (tmo_q == TMO_LAST) &&
                   ((state_q == GET_ADDR) || (state_q == GET_DATA));

  for (genvar k = 0; k < 8; k++) begin : g_regs_out
    assign regs_o[8*k +: 8] = regs_q[k];
  end

  // Command decode, reply selection and timeout bookkeeping.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    reply_d = reply_q;
    tmo_d   = tmo_q;
    err_inc = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = 16'd0;
        if (rx_fire) begin
          if ((out_data_i == CH_R) || (out_data_i == CH_W)) begin
            op_wr_d = (out_data_i == CH_W);
            state_d = GET_ADDR;
          end else if (out_data_i == CH_V) begin
            reply_d = VERSION;
            state_d = RESP;
          end else if ((out_data_i != CH_CR) && (out_data_i != CH_LF)) begin
            reply_d = CH_ERR;
            err_inc = 1'b1;
            state_d = RESP;
          end
        end
      end
      GET_ADDR, GET_DATA: begin
        if (rx_fire) begin
          tmo_d = 16'd0;
          if (state_q == GET_ADDR && op_wr_q) begin
            addr_d  = out_data_i;
            state_d = GET_DATA;
          end else begin
            state_d = RESP;
            if (state_q == GET_ADDR) begin
              if (out_data_i < 8'd8) begin
                reply_d = regs_q[out_data_i[2:0]];
              end else begin
                reply_d = CH_ERR;
                err_inc = 1'b1;
              end
            end else if (addr_q < 8'd8) begin
              wr_en   = 1'b1;
              reply_d = CH_OK;
            end else begin
              reply_d = CH_ERR;
              err_inc = 1'b1;
            end
          end
        end else if (tmo_hit) begin
          tmo_d   = 16'd0;
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      RESP: begin
        tmo_d = 16'd0;
        if (tx_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  // Control and status registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      addr_q  <= 8'd0;
      reply_q <= 8'd0;
      err_q   <= 8'd0;
      tmo_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      reply_q <= reply_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Register file; written only when the data byte of a valid write lands.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'd0;
    end else if (wr_en) begin
      regs_q[addr_q[2:0]] <= out_data_i;
    end
  end

endmodule

// File: tb/tb_cdc_reg_responder.sv
// Scoreboard bench for cdc_reg_responder: directed scenarios plus random traffic.
module tb_cdc_reg_responder;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [7:0]  out_data_i = 8'd0;
  logic        out_valid_i = 1'b0;
  logic        out_ready_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i = 1'b1;
  logic [63:0] regs_o;
  logic [7:0]  err_count_o;

  int total = 0;
  int bad = 0;
  bit rnd_mode = 1'b0;

  logic [7:0] m_regs [8];
  int         m_err;
  logic [7:0] cmd_q [$];
  logic [7:0] exp_q [$];

  cdc_reg_responder #(.VERSION(8'h01), .TIMEOUT_CYCLES(16'd16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .regs_o(regs_o), .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_flat();
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = m_regs[k];
    return r;
  endfunction

  task automatic m_err_inc();
    if (m_err < 255) m_err++;
  endtask

  task automatic m_reset();
    for (int k = 0; k < 8; k++) m_regs[k] = 8'd0;
    m_err = 0;
    cmd_q.delete();
    exp_q.delete();
  endtask

  // Command-level reference: bytes collected until a command is complete.
  task automatic model_byte(input logic [7:0] b, input int gap);
    logic [7:0] a;
    if (cmd_q.size() != 0 && gap >= 16) begin
      cmd_q.delete();
      m_err_inc();
    end
    if (cmd_q.size() == 0) begin
      if (b == 8'h0D || b == 8'h0A) begin
      end else if (b == 8'h52 || b == 8'h57) begin
        cmd_q.push_back(b);
      end else if (b == 8'h56) begin
        exp_q.push_back(8'h01);
      end else begin
        exp_q.push_back(8'h3F);
        m_err_inc();
      end
    end else if (cmd_q[0] == 8'h52) begin
      if (b < 8'd8) exp_q.push_back(m_regs[b[2:0]]);
      else begin exp_q.push_back(8'h3F); m_err_inc(); end
      cmd_q.delete();
    end else if (cmd_q.size() == 1) begin
      cmd_q.push_back(b);
    end else begin
      a = cmd_q[1];
      if (a < 8'd8) begin m_regs[a[2:0]] = b; exp_q.push_back(8'h4B); end
      else begin exp_q.push_back(8'h3F); m_err_inc(); end
      cmd_q.delete();
    end
  endtask

  // Called and returns #1 after a rising edge.
  task automatic send(input logic [7:0] b, input int gap);
    bit done = 1'b0;
    repeat (gap) begin @(posedge clk_i); #1; end
    out_valid_i = 1'b1;
    out_data_i  = b;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk_i);
      if (out_ready_o) begin
        @(posedge clk_i); #1;
        done = 1'b1;
      end
    end
    out_valid_i = 1'b0;
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic sb(input logic [7:0] b, input int gap);
    model_byte(b, gap);
    send(b, gap);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    #2;
    check("rst_valid", in_valid_o, 1'b0);
    check("rst_ready", out_ready_o, 1'b1);
    check("rst_data", in_data_o, 8'h00);
    check("rst_regs", regs_o, 64'd0);
    check("rst_err", err_count_o, 8'h00);
    m_reset();
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
  endtask

  // Monitor: a reply is consumed on the edge following this sample point.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk_i);
      if (rstn_i && in_valid_o && in_ready_i) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL reply_unexpected: got %0h expected none", in_data_o);
        end else begin
          e = exp_q.pop_front();
          check("reply", in_data_o, e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i); #1;
      if (rnd_mode) in_ready_i = ($urandom_range(3) != 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int g;
    int kind;
    @(posedge clk_i); #1;
    do_reset();

    // Back-to-back write, reply and register visible one cycle later.
    sb(8'h57, 0); sb(8'h03, 0); sb(8'hA5, 0);
    check("w_lat_valid", in_valid_o, 1'b1);
    check("w_lat_data", in_data_o, 8'h4B);
    check("w_lat_reg3", regs_o[31:24], 8'hA5);
    drain();

    // Read with the host stalling the reply for five cycles.
    in_ready_i = 1'b0;
    sb(8'h52, 0); sb(8'h03, 0);
    for (int i = 0; i < 5; i++) begin
      check("stall_data", in_data_o, 8'hA5);
      check("stall_valid", in_valid_o, 1'b1);
      check("stall_ready", out_ready_o, 1'b0);
      @(posedge clk_i); #1;
    end
    in_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("release_ready", out_ready_o, 1'b1);
    check("release_valid", in_valid_o, 1'b0);
    check("err_zero", err_count_o, 8'd0);

    // Bad address and unknown command, then ignored CR/LF.
    sb(8'h52, 0); sb(8'h09, 0); sb(8'h58, 0);
    drain();
    check("err_two", err_count_o, 8'd2);
    sb(8'h0D, 0); sb(8'h0A, 0);
    check("crlf_noreply", in_valid_o, 1'b0);
    repeat (3) begin @(posedge clk_i); #1; end

    // Timeout after 16 quiet cycles, then a byte on the last allowed cycle.
    sb(8'h57, 0); sb(8'h01, 0);
    repeat (16) begin @(posedge clk_i); #1; end
    cmd_q.delete(); m_err_inc();
    check("tmo_noreply", in_valid_o, 1'b0);
    check("tmo_regs", regs_o, m_flat());
    check("tmo_err", err_count_o, 8'd3);
    sb(8'h57, 0); sb(8'h01, 0); sb(8'h77, 15);
    drain();
    check("tmo_edge_reg1", regs_o[15:8], 8'h77);

    // Reset in the middle of a write.
    sb(8'h57, 0); sb(8'h02, 0);
    do_reset();
    sb(8'h55, 0);
    drain();
    check("rst_mid_reg2", regs_o[23:16], 8'h00);
    check("rst_mid_err", err_count_o, 8'd1);

    // Saturation of the error counter, then version.
    for (int i = 0; i < 256; i++) sb(8'h58, 0);
    drain();
    check("err_sat", err_count_o, 8'hFF);
    sb(8'h56, 0);
    drain();

    // Random traffic.
    rnd_mode = 1'b1;
    for (int it = 0; it < 250; it++) begin
      kind = $urandom_range(9);
      for (int j = 0; j < 3; j++) begin
        g = ($urandom_range(19) == 0) ? $urandom_range(18, 14) : $urandom_range(2);
        b = 8'($urandom_range(255));
        case (kind)
          0, 1: begin sb(b, g); j = 3; end
          2, 3, 4: begin
            if (j == 0) sb(8'h52, g);
            else begin sb(8'($urandom_range(11)), g); j = 3; end
          end
          5, 6, 7: begin
            if (j == 0) sb(8'h57, g);
            else if (j == 1) sb(8'($urandom_range(11)), g);
            else sb(b, g);
          end
          8: begin sb(8'h56, g); j = 3; end
          default: begin sb((b[0] ? 8'h0D : 8'h0A), g); j = 3; end
        endcase
      end
      if (it % 25 == 24) begin
        drain();
        check("rnd_regs", regs_o, m_flat());
        check("rnd_err", err_count_o, m_err);
      end
    end
    rnd_mode = 1'b0;
    in_ready_i = 1'b1;
    drain();
    check("final_regs", regs_o, m_flat());
    check("final_err", err_count_o, m_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
